// File: rtl/alu_issue_controller_if.sv
// Issue-stage bus: instruction handshake, arithmetic-unit drive/return, completion report, debug read.
// master = issue controller side, slave = environment (instruction source, arithmetic unit, sink).
interface alu_issue_controller_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              iInstValid;
    logic              oInstReady;
    logic [1:0]        iInstOp;
    logic [REG_AW-1:0] iInstDst;
    logic [REG_AW-1:0] iInstSrcA;
    logic [REG_AW-1:0] iInstSrcB;
    logic [DATA_W-1:0] iInstImm;

    logic [DATA_W-1:0] oPortA;
    logic [DATA_W-1:0] oPortB;
    logic [1:0]        oOpcode;
    logic [DATA_W-1:0] iAccumulator;
    logic              iCarryflag;
    logic              iZeroflag;

    logic              oDoneValid;
    logic [REG_AW-1:0] oDoneDst;
    logic [DATA_W-1:0] oDoneData;
    logic              oDoneCarry;
    logic              oDoneZero;

    logic [REG_AW-1:0] iDbgAddr;
    logic [DATA_W-1:0] oDbgData;

    modport master (
        input  iInstValid, iInstOp, iInstDst, iInstSrcA, iInstSrcB, iInstImm,
        input  iAccumulator, iCarryflag, iZeroflag, iDbgAddr,
        output oInstReady, oPortA, oPortB, oOpcode,
        output oDoneValid, oDoneDst, oDoneData, oDoneCarry, oDoneZero, oDbgData
    );

    modport slave (
        output iInstValid, iInstOp, iInstDst, iInstSrcA, iInstSrcB, iInstImm,
        output iAccumulator, iCarryflag, iZeroflag, iDbgAddr,
        input  oInstReady, oPortA, oPortB, oOpcode,
        input  oDoneValid, oDoneDst, oDoneData, oDoneCarry, oDoneZero, oDbgData
    );
endinterface

// File: rtl/alu_issue_controller.sv
// Single-issue front end for the 16-bit arithmetic unit: regfile read, one execute cycle, writeback.
// Latency accept->done 3 cycles (ALU) / 1 cycle (LDI); ready only in IDLE, done pulse has no backpressure.
module alu_issue_controller #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic iClock,
    input  logic iReset,
    alu_issue_controller_if.master bus
);
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} stateE;

    stateE             state;
    stateE             nextState;

    logic [DATA_W-1:0] regFile [NREG];
    logic [REG_AW-1:0] dstReg;
    logic [REG_AW-1:0] srcAReg;
    logic [REG_AW-1:0] srcBReg;
    logic [1:0]        instOpReg;
    logic [1:0]        opcodeReg;
    logic [DATA_W-1:0] operandA;
    logic [DATA_W-1:0] operandB;
    logic [DATA_W-1:0] doneData;
    logic              doneZero;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState       = state;
        bus.oInstReady  = 1'b0;
        bus.oDoneValid  = 1'b0;
        // Outside EXEC, FFFF + carry reproduces the carry, so the unit's carry flop holds its value.
        bus.oOpcode     = OP_ADD;
        bus.oPortA      = '1;
        bus.oPortB      = {{(DATA_W-1){1'b0}}, bus.iCarryflag};
        case (state)
            IDLE: begin
                bus.oInstReady = 1'b1;
                if (bus.iInstValid) begin
                    nextState = (bus.iInstOp == OP_LDI) ? WB : READ;
                end
            end
            READ: nextState = EXEC;
            EXEC: begin
                nextState   = WB;
                bus.oOpcode = opcodeReg;
                bus.oPortA  = operandA;
                bus.oPortB  = operandB;
            end
            WB: begin
                nextState      = IDLE;
                bus.oDoneValid = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < NREG; i++) begin
                regFile[i] <= '0;
            end
            dstReg    <= '0;
            srcAReg   <= '0;
            srcBReg   <= '0;
            instOpReg <= '0;
            opcodeReg <= '0;
            operandA  <= '0;
            operandB  <= '0;
            doneData  <= '0;
            doneZero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iInstValid) begin
                        dstReg    <= bus.iInstDst;
                        srcAReg   <= bus.iInstSrcA;
                        srcBReg   <= bus.iInstSrcB;
                        instOpReg <= bus.iInstOp;
                        // LDI completes entirely at the accept edge; the arithmetic unit is bypassed.
                        if (bus.iInstOp == OP_LDI) begin
                            regFile[bus.iInstDst] <= bus.iInstImm;
                            doneData              <= bus.iInstImm;
                            doneZero              <= (bus.iInstImm == '0);
                        end
                    end
                end
                READ: begin
                    operandA  <= regFile[srcAReg];
                    operandB  <= regFile[srcBReg];
                    opcodeReg <= instOpReg;
                end
                EXEC: begin
                    regFile[dstReg] <= bus.iAccumulator;
                    doneData        <= bus.iAccumulator;
                    doneZero        <= bus.iZeroflag;
                end
                default: ;
            endcase
        end
    end

    assign bus.oDoneDst   = dstReg;
    assign bus.oDoneData  = doneData;
    assign bus.oDoneZero  = doneZero;
    assign bus.oDoneCarry = bus.iCarryflag;
    assign bus.oDbgData   = regFile[bus.iDbgAddr];
endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed bench for alu_issue_controller with a behavioural arithmetic unit (combinational result,
// carry flop updating every edge; SUB forces carry to 0).
module tb_alu_issue_controller;
    logic iClock = 1'b0;
    logic iReset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    alu_issue_controller_if #(.DATA_W(16), .REG_AW(3)) bus ();

    alu_issue_controller #(.DATA_W(16), .NREG(8), .REG_AW(3)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    // Arithmetic unit model
    logic [16:0] aluSum;
    logic        carryQ;
    always_comb begin
        aluSum = '0;
        case (bus.oOpcode)
            2'b01:   aluSum = {1'b0, bus.oPortA} + {1'b0, bus.oPortB};
            2'b10:   aluSum = {1'b0, bus.oPortA} + {1'b0, bus.oPortB} + {16'b0, carryQ};
            2'b11:   aluSum = {1'b0, bus.oPortA - bus.oPortB};
            default: aluSum = {carryQ, bus.oPortA};
        endcase
    end
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) carryQ <= 1'b0;
        else        carryQ <= aluSum[16];
    end
    assign bus.iAccumulator = aluSum[15:0];
    assign bus.iCarryflag   = carryQ;
    assign bus.iZeroflag    = (aluSum[15:0] == 16'h0000);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic checkReg(input logic [2:0] addr, input logic [15:0] exp);
        bus.iDbgAddr = addr;
        #1;
        check($sformatf("dbgReg%0d", addr), 32'(bus.oDbgData), 32'(exp));
    endtask

    // Called #1 after a rising edge with the controller idle; returns the same way.
    task automatic runInst(input string tag, input logic [1:0] op, input logic [2:0] dst,
                           input logic [2:0] srcA, input logic [2:0] srcB, input logic [15:0] imm,
                           input int expLat, input logic [15:0] expData,
                           input logic expCarry, input logic expZero);
        int n;
        bus.iInstValid = 1'b1;
        bus.iInstOp    = op;
        bus.iInstDst   = dst;
        bus.iInstSrcA  = srcA;
        bus.iInstSrcB  = srcB;
        bus.iInstImm   = imm;
        @(posedge iClock); #1;
        bus.iInstValid = 1'b0;
        n = 1;
        while (!bus.oDoneValid && n < 10) begin
            @(posedge iClock); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(expLat));
        check({tag, ".doneValid"}, 32'(bus.oDoneValid), 32'd1);
        check({tag, ".doneDst"}, 32'(bus.oDoneDst), 32'(dst));
        check({tag, ".doneData"}, 32'(bus.oDoneData), 32'(expData));
        check({tag, ".doneCarry"}, 32'(bus.oDoneCarry), 32'(expCarry));
        check({tag, ".doneZero"}, 32'(bus.oDoneZero), 32'(expZero));
        @(posedge iClock); #1;
        check({tag, ".pulseWidth"}, 32'(bus.oDoneValid), 32'd0);
    endtask

    initial begin
        int pulses;
        bus.iInstValid = 1'b0;
        bus.iInstOp    = 2'b00;
        bus.iInstDst   = '0;
        bus.iInstSrcA  = '0;
        bus.iInstSrcB  = '0;
        bus.iInstImm   = '0;
        bus.iDbgAddr   = '0;

        // 1: reset state
        repeat (2) @(posedge iClock);
        #1;
        check("rstReadyDuring", 32'(bus.oInstReady), 32'd1);
        iReset = 1'b0;
        @(posedge iClock); #1;
        check("rstReady", 32'(bus.oInstReady), 32'd1);
        check("rstPortA", 32'(bus.oPortA), 32'h0000FFFF);
        check("rstPortB", 32'(bus.oPortB), 32'h00000000);
        check("rstOpcode", 32'(bus.oOpcode), 32'd1);
        check("rstDoneValid", 32'(bus.oDoneValid), 32'd0);
        for (int i = 0; i < 8; i++) checkReg(3'(i), 16'h0000);

        // 2: LDI, LDI, ADD with carry out
        runInst("ldiR1", 2'b00, 3'd1, 3'd0, 3'd0, 16'h8000, 1, 16'h8000, 1'b0, 1'b0);
        runInst("ldiR2", 2'b00, 3'd2, 3'd0, 3'd0, 16'h8001, 1, 16'h8001, 1'b0, 1'b0);
        runInst("addR3", 2'b01, 3'd3, 3'd1, 3'd2, 16'h0000, 3, 16'h0001, 1'b1, 1'b0);
        checkReg(3'd3, 16'h0001);

        // 3: idle gap keeps carry; ADC consumes it
        repeat (10) @(posedge iClock);
        #1;
        check("idleHoldPortB", 32'(bus.oPortB), 32'h00000001);
        check("idleHoldOpcode", 32'(bus.oOpcode), 32'd1);
        runInst("adcR4", 2'b10, 3'd4, 3'd2, 3'd0, 16'h0000, 3, 16'h8002, 1'b0, 1'b0);
        checkReg(3'd4, 16'h8002);

        // 4: SUB to zero, then ADC of zeros with cleared carry
        runInst("subR5", 2'b11, 3'd5, 3'd1, 3'd1, 16'h0000, 3, 16'h0000, 1'b0, 1'b1);
        runInst("adcR6", 2'b10, 3'd6, 3'd0, 3'd0, 16'h0000, 3, 16'h0000, 1'b0, 1'b1);
        checkReg(3'd5, 16'h0000);

        // 5: valid held high, fields changing while busy
        @(posedge iClock); #1;
        bus.iInstValid = 1'b1;
        bus.iInstOp    = 2'b01;
        bus.iInstDst   = 3'd7;
        bus.iInstSrcA  = 3'd1;
        bus.iInstSrcB  = 3'd2;
        @(posedge iClock); #1;
        check("busyReady", 32'(bus.oInstReady), 32'd0);
        bus.iInstOp  = 2'b00;
        bus.iInstDst = 3'd0;
        bus.iInstImm = 16'hDEAD;
        @(posedge iClock); #1;
        bus.iInstOp   = 2'b11;
        bus.iInstDst  = 3'd3;
        bus.iInstSrcA = 3'd4;
        bus.iInstSrcB = 3'd2;
        @(posedge iClock); #1;
        check("holdDoneValid", 32'(bus.oDoneValid), 32'd1);
        check("holdDoneDst", 32'(bus.oDoneDst), 32'd7);
        check("holdDoneData", 32'(bus.oDoneData), 32'h00000001);
        check("holdDoneCarry", 32'(bus.oDoneCarry), 32'd1);
        bus.iInstValid = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge iClock); #1;
            if (bus.oDoneValid) pulses++;
        end
        check("holdExtraPulses", 32'(pulses), 32'd0);
        checkReg(3'd7, 16'h0001);
        checkReg(3'd0, 16'h0000);
        checkReg(3'd3, 16'h0001);

        // 6: reset during EXEC discards the instruction
        @(posedge iClock); #1;
        bus.iInstValid = 1'b1;
        bus.iInstOp    = 2'b01;
        bus.iInstDst   = 3'd3;
        bus.iInstSrcA  = 3'd1;
        bus.iInstSrcB  = 3'd2;
        @(posedge iClock); #1;
        bus.iInstValid = 1'b0;
        @(posedge iClock); #1;
        check("execOpcode", 32'(bus.oOpcode), 32'd1);
        check("execPortA", 32'(bus.oPortA), 32'h00008000);
        iReset = 1'b1;
        #1;
        check("midRstReady", 32'(bus.oInstReady), 32'd1);
        check("midRstPortA", 32'(bus.oPortA), 32'h0000FFFF);
        check("midRstDoneValid", 32'(bus.oDoneValid), 32'd0);
        @(posedge iClock); #1;
        iReset = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(posedge iClock); #1;
            if (bus.oDoneValid) pulses++;
        end
        check("postRstPulses", 32'(pulses), 32'd0);
        check("postRstReady", 32'(bus.oInstReady), 32'd1);
        check("postRstDoneData", 32'(bus.oDoneData), 32'h00000000);
        for (int i = 0; i < 8; i++) checkReg(3'(i), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
